// File: rtl/mmio_fifo_pkg.sv
// Shared register offsets, STATUS bit positions and STATUS word layout for the MMIO FIFO port.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package mmio_fifo_pkg;

   // Register offsets from BASE_ADDR, in CCI-P 4-byte address units.
   localparam logic [15:0] DATA_OFS   = 16'd0;
   localparam logic [15:0] STATUS_OFS = 16'd2;
   localparam logic [15:0] PEEK_OFS   = 16'd4;

   // STATUS word bit positions.
   localparam int ST_COUNT_LSB = 0;
   localparam int ST_COUNT_MSB = 7;
   localparam int ST_EMPTY_BIT = 8;
   localparam int ST_FULL_BIT  = 9;
   localparam int ST_OVF_BIT   = 10;
   localparam int ST_UDF_BIT   = 11;

   // STATUS word as returned on a read of BASE+STATUS_OFS.
   typedef struct packed {
      logic [51:0] reserved;
      logic        underflow;
      logic        overflow;
      logic        full;
      logic        empty;
      logic [7:0]  count;
   } t_mmio_fifo_status;

endpackage

// File: rtl/mmio_fifo_ram.sv
// DEPTH x DATA_W FIFO storage: synchronous write at the write pointer, combinational read at the read pointer.
// Latency: write visible on the read port the cycle after the write edge; read is zero-cycle.
// Backpressure: none; the caller gates i_wr_en on fullness.
module mmio_fifo_ram #(
   parameter int DEPTH  = 8,
   parameter int DATA_W = 64,
   parameter int PW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              i_wr_en,
   input  logic [PW-1:0]     i_wr_addr,
   input  logic [DATA_W-1:0] i_wr_data,
   input  logic [PW-1:0]     i_rd_addr,
   output logic [DATA_W-1:0] o_rd_data
);

   logic [DATA_W-1:0] r_mem [DEPTH];

   // Storage write; contents are intentionally not reset.
   always_ff @(posedge clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_data;
      end
   end

   assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/mmio_fifo_port.sv
// Host-facing MMIO FIFO: DATA writes push, DATA reads pop, STATUS reads report occupancy and sticky flags.
// Latency: read response exactly 1 cycle after the MMIO read strobe, single-cycle pulse.
// Backpressure: none; pushes to a full FIFO are dropped (overflow), pops of an empty FIFO return 0 (underflow).
// Optional: define MMIO_FIFO_PEEK_EN to map a non-popping PEEK register at BASE+4.
module mmio_fifo_port
   import mmio_fifo_pkg::*;
#(
   parameter int          DEPTH     = 8,
   parameter int          DATA_W    = 64,
   parameter logic [15:0] BASE_ADDR = 16'h0030
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_mmio_wr_valid,
   input  logic                     i_mmio_rd_valid,
   input  logic [15:0]              i_mmio_addr,
   input  logic [8:0]               i_mmio_tid,
   input  logic [DATA_W-1:0]        i_mmio_wdata,
   output logic                     o_rsp_valid,
   output logic [8:0]               o_rsp_tid,
   output logic [DATA_W-1:0]        o_rsp_data,
   output logic [$clog2(DEPTH):0]   o_count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [PW-1:0]     r_wptr;
   logic [PW-1:0]     r_rptr;
   logic [CW-1:0]     r_count;
   logic              r_overflow;
   logic              r_underflow;
   logic              r_rsp_valid;
   logic [8:0]        r_rsp_tid;
   logic [DATA_W-1:0] r_rsp_data;

   logic              w_hit_data;
   logic              w_hit_status;
   logic              w_wr_data;
   logic              w_wr_status;
   logic              w_rd_data;
   logic              w_rd_status;
   logic              w_rd_peek;
   logic              w_rd_hit;
   logic              w_empty;
   logic              w_full;
   logic              w_push;
   logic              w_pop;
   logic [DATA_W-1:0] w_ram_rdata;
   logic [DATA_W-1:0] w_rsp_data;
   t_mmio_fifo_status w_status;

   // Address decode; wr and rd share one address, so at most one register is targeted per cycle.
   assign w_hit_data   = (i_mmio_addr == (BASE_ADDR + DATA_OFS));
   assign w_hit_status = (i_mmio_addr == (BASE_ADDR + STATUS_OFS));
   assign w_wr_data    = i_mmio_wr_valid & w_hit_data;
   assign w_wr_status  = i_mmio_wr_valid & w_hit_status;
   assign w_rd_data    = i_mmio_rd_valid & w_hit_data;
   assign w_rd_status  = i_mmio_rd_valid & w_hit_status;
`ifdef MMIO_FIFO_PEEK_EN
   assign w_rd_peek    = i_mmio_rd_valid & (i_mmio_addr == (BASE_ADDR + PEEK_OFS));
`else
   assign w_rd_peek    = 1'b0;
`endif
   assign w_rd_hit     = w_rd_data | w_rd_status | w_rd_peek;

   // Push and pop both judge fullness/emptiness on pre-update state: no bypass in either direction.
   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CW'(DEPTH));
   assign w_push  = w_wr_data & ~w_full;
   assign w_pop   = w_rd_data & ~w_empty;

   mmio_fifo_ram #(
      .DEPTH  (DEPTH),
      .DATA_W (DATA_W),
      .PW     (PW)
   ) u_ram (
      .clk       (clk),
      .i_wr_en   (w_push),
      .i_wr_addr (r_wptr),
      .i_wr_data (i_mmio_wdata),
      .i_rd_addr (r_rptr),
      .o_rd_data (w_ram_rdata)
   );

   // Status word assembled from current (pre-update) state.
   always_comb begin
      w_status           = '0;
      w_status.count     = 8'(r_count);
      w_status.empty     = w_empty;
      w_status.full      = w_full;
      w_status.overflow  = r_overflow;
      w_status.underflow = r_underflow;
   end

   // Response data select: status, or head entry for pop/peek, zero when empty.
   always_comb begin
      w_rsp_data = '0;
      if (w_rd_status) begin
         w_rsp_data = DATA_W'(w_status);
      end else if ((w_rd_data | w_rd_peek) && !w_empty) begin
         w_rsp_data = w_ram_rdata;
      end
   end

   // Pointer and occupancy update; pointers wrap naturally at DEPTH (power of two).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wptr <= r_wptr + PW'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Sticky overflow/underflow flags; any STATUS write clears both.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else if (w_wr_status) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         if (w_wr_data && w_full) begin
            r_overflow <= 1'b1;
         end
         if (w_rd_data && w_empty) begin
            r_underflow <= 1'b1;
         end
      end
   end

   // One-cycle read response register; tid/data hold between pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_valid <= 1'b0;
         r_rsp_tid   <= '0;
         r_rsp_data  <= '0;
      end else begin
         r_rsp_valid <= w_rd_hit;
         if (w_rd_hit) begin
            r_rsp_tid  <= i_mmio_tid;
            r_rsp_data <= w_rsp_data;
         end
      end
   end

   assign o_rsp_valid = r_rsp_valid;
   assign o_rsp_tid   = r_rsp_tid;
   assign o_rsp_data  = r_rsp_data;
   assign o_count     = r_count;

endmodule

// File: tb/tb_mmio_fifo_port.sv
// Randomized plus directed bench for mmio_fifo_port against a queue-based reference model.
// Latency: checks every response one cycle after its MMIO strobe.
// Backpressure: none exercised; DUT has none.
module tb_mmio_fifo_port;

   localparam int          DEPTH = 8;
   localparam logic [15:0] BASE  = 16'h0030;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        wr_v, rd_v;
   logic [15:0] addr;
   logic [8:0]  tid;
   logic [63:0] wdata;
   logic        rsp_v;
   logic [8:0]  rsp_tid;
   logic [63:0] rsp_data;
   logic [3:0]  cnt;

   int n_chk  = 0;
   int n_fail = 0;

   logic [63:0] mq[$];
   bit          m_ovf, m_udf;
   logic [63:0] last_rsp;

   always #5 clk = ~clk;

   mmio_fifo_port #(
      .DEPTH     (DEPTH),
      .DATA_W    (64),
      .BASE_ADDR (BASE)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_mmio_wr_valid (wr_v),
      .i_mmio_rd_valid (rd_v),
      .i_mmio_addr     (addr),
      .i_mmio_tid      (tid),
      .i_mmio_wdata    (wdata),
      .o_rsp_valid     (rsp_v),
      .o_rsp_tid       (rsp_tid),
      .o_rsp_data      (rsp_data),
      .o_count         (cnt)
   );

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   function automatic logic [63:0] model_status();
      int sz;
      sz = mq.size();
      return 64'(sz) + ((sz == 0) ? 64'h100 : 64'h0) + ((sz == DEPTH) ? 64'h200 : 64'h0)
           + (m_ovf ? 64'h400 : 64'h0) + (m_udf ? 64'h800 : 64'h0);
   endfunction

   // One MMIO cycle: drive, predict from the model, advance, check.
   task automatic op(input bit wr, input bit rd, input logic [15:0] a, input logic [8:0] t,
                     input logic [63:0] d);
      bit          exp_v, pop_ok, push_ok, set_ovf, set_udf, clr;
      logic [63:0] exp_d;
      @(negedge clk);
      wr_v = wr; rd_v = rd; addr = a; tid = t; wdata = d;
      exp_v = 0; exp_d = 0; pop_ok = 0; push_ok = 0; set_ovf = 0; set_udf = 0; clr = 0;
      if (rd && a == BASE) begin
         exp_v = 1;
         if (mq.size() > 0) begin exp_d = mq[0]; pop_ok = 1; end
         else set_udf = 1;
      end
      if (rd && a == BASE + 16'd2) begin
         exp_v = 1;
         exp_d = model_status();
      end
`ifdef MMIO_FIFO_PEEK_EN
      if (rd && a == BASE + 16'd4) begin
         exp_v = 1;
         exp_d = (mq.size() > 0) ? mq[0] : 64'h0;
      end
`endif
      if (wr && a == BASE) begin
         if (mq.size() < DEPTH) push_ok = 1;
         else set_ovf = 1;
      end
      if (wr && a == BASE + 16'd2) clr = 1;
      if (pop_ok) void'(mq.pop_front());
      if (push_ok) mq.push_back(d);
      if (clr) begin m_ovf = 0; m_udf = 0; end
      if (set_ovf) m_ovf = 1;
      if (set_udf) m_udf = 1;
      @(posedge clk);
      #1;
      chk("rsp_vld", 64'(rsp_v), 64'(exp_v));
      if (exp_v) begin
         chk("rsp_tid", 64'(rsp_tid), 64'(t));
         chk("rsp_dat", rsp_data, exp_d);
      end
      chk("count", 64'(cnt), 64'(mq.size()));
      last_rsp = rsp_data;
      wr_v = 0; rd_v = 0;
   endtask

   initial begin
      logic [15:0] atab [6];
      int          kind;
      atab[0] = BASE; atab[1] = BASE; atab[2] = BASE; atab[3] = BASE + 16'd2;
      atab[4] = BASE + 16'd4; atab[5] = BASE + 16'd6;
      wr_v = 0; rd_v = 0; addr = 0; tid = 0; wdata = 0;
      m_ovf = 0; m_udf = 0; last_rsp = 0;

      #12;
      chk("reset_count", 64'(cnt), 64'h0);
      chk("reset_vld", 64'(rsp_v), 64'h0);
      chk("reset_tid", 64'(rsp_tid), 64'h0);
      chk("reset_dat", rsp_data, 64'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // Empty status after reset.
      op(0, 1, BASE + 16'd2, 9'd5, 0);
      chk("stat_after_reset", last_rsp, 64'h100);

      // In-order A, B, C.
      op(1, 0, BASE, 9'd1, 64'hA);
      op(1, 0, BASE, 9'd1, 64'hB);
      op(1, 0, BASE, 9'd1, 64'hC);
      op(0, 1, BASE, 9'd10, 0); chk("pop_a", last_rsp, 64'hA);
      op(0, 1, BASE, 9'd11, 0); chk("pop_b", last_rsp, 64'hB);
      op(0, 1, BASE, 9'd12, 0); chk("pop_c", last_rsp, 64'hC);
      op(0, 0, BASE, 9'd0, 0);
      op(0, 1, BASE + 16'd2, 9'd3, 0);
      chk("stat_drained", last_rsp, 64'h100);

      // Overflow: 9 pushes into 8 entries.
      for (int i = 1; i <= 9; i++) op(1, 0, BASE, 9'd0, 64'(i));
      op(0, 1, BASE + 16'd2, 9'd7, 0);
      chk("stat_full_ovf", last_rsp, 64'h608);
      for (int i = 1; i <= 8; i++) op(0, 1, BASE, 9'(i), 0);
      chk("pop_last_is_8", last_rsp, 64'h8);

      // Underflow, then clear.
      op(1, 0, BASE + 16'd2, 9'd0, 64'hFFFF);
      op(0, 1, BASE, 9'd20, 0);
      chk("pop_empty_dat", last_rsp, 64'h0);
      op(0, 1, BASE + 16'd2, 9'd21, 0);
      chk("stat_udf", last_rsp, 64'h900);
      op(1, 0, BASE + 16'd2, 9'd0, 0);
      op(0, 1, BASE + 16'd2, 9'd22, 0);
      chk("stat_cleared", last_rsp, 64'h100);

      // Interleaved traffic across the pointer wrap.
      for (int i = 0; i < 4; i++) op(1, 0, BASE, 9'd0, 64'h100 + 64'(i));
      for (int i = 4; i < 12; i++) begin
         op(1, 0, BASE, 9'd0, 64'h100 + 64'(i));
         op(0, 1, BASE, 9'(i), 0);
      end
      for (int i = 0; i < 4; i++) op(0, 1, BASE, 9'(i), 0);
      chk("wrap_last", last_rsp, 64'h10B);

      // Same-cycle push+pop on empty: underflow, count ends at 1.
      op(1, 1, BASE, 9'd30, 64'hEE);
      chk("pushpop_empty_dat", last_rsp, 64'h0);
      for (int i = 0; i < 7; i++) op(1, 0, BASE, 9'd0, 64'h200 + 64'(i));
      // Same-cycle push+pop on full: push dropped, count 7.
      op(1, 1, BASE, 9'd31, 64'hDD);
      op(1, 0, BASE + 16'd2, 9'd0, 0);

      // PEEK (or unmapped when the feature is off), plus unmapped reads.
      while (mq.size() > 0) op(0, 1, BASE, 9'd0, 0);
      op(1, 0, BASE, 9'd0, 64'h55);
      op(0, 1, BASE + 16'd4, 9'd40, 0);
      op(0, 1, BASE + 16'd4, 9'd41, 0);
`ifdef MMIO_FIFO_PEEK_EN
      chk("peek_dat", last_rsp, 64'h55);
`endif
      op(1, 0, BASE + 16'd4, 9'd0, 64'h77);
      op(0, 1, BASE + 16'd6, 9'd42, 0);
      op(0, 1, BASE + 16'd1, 9'd43, 0);
      op(1, 0, BASE + 16'd1, 9'd0, 64'h99);
      op(0, 1, BASE, 9'd44, 0);
      chk("after_unmapped_pop", last_rsp, 64'h55);

      // Asynchronous reset with 3 words stored and a response in flight.
      for (int i = 0; i < 3; i++) op(1, 0, BASE, 9'd0, 64'h300 + 64'(i));
      op(0, 1, BASE + 16'd2, 9'd50, 0);
      #1 rst_n = 1'b0;
      #1;
      chk("arst_count", 64'(cnt), 64'h0);
      chk("arst_vld", 64'(rsp_v), 64'h0);
      mq.delete(); m_ovf = 0; m_udf = 0;
      @(negedge clk);
      rst_n = 1'b1;
      op(0, 1, BASE + 16'd2, 9'd51, 0);
      chk("stat_after_arst", last_rsp, 64'h100);

      // Randomized traffic.
      for (int n = 0; n < 500; n++) begin
         kind = $urandom_range(0, 9);
         if (kind <= 4)
            op(1, 0, atab[$urandom_range(0, 5)], 9'($urandom), {$urandom, $urandom});
         else if (kind <= 7)
            op(0, 1, atab[$urandom_range(0, 5)], 9'($urandom), 0);
         else if (kind == 8)
            op(1, 1, atab[$urandom_range(0, 5)], 9'($urandom), {$urandom, $urandom});
         else
            op(0, 0, BASE, 9'd0, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
